// File: rtl/key_event_decoder_pkg.sv
// Shared state encoding and default 1 MHz timing constants for the key event decoder.
// Imported by the decoder, its controller and the bench.
package key_event_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HELD  = 3'd1,
        ST_LONG  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int DEF_LONG_TIME     = 1_000_000;
    localparam int DEF_DCLICK_GAP    = 300_000;
    localparam int DEF_REPEAT_PERIOD = 100_000;
    localparam int DEF_CNT_W         = 20;

endpackage

// File: rtl/key_event_decoder.sv
// Turns debounced press/release pulses into short/long/repeat/double-click pulses.
// Registered outputs, one cycle after the deciding edge; no backpressure (events are fire-and-forget).
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int LONG_TIME     = DEF_LONG_TIME,
    parameter int DCLICK_GAP    = DEF_DCLICK_GAP,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pressed,
    input  logic key_released,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic double_click,
    output logic key_busy
);

    generate
        if (LONG_TIME < 2 || DCLICK_GAP < 2 || REPEAT_PERIOD < 2) begin : g_bad_time
            $error("key_event_decoder: every time parameter must be >= 2");
        end
        if (LONG_TIME >= (2 ** CNT_W) || DCLICK_GAP >= (2 ** CNT_W) ||
            REPEAT_PERIOD >= (2 ** CNT_W)) begin : g_bad_width
            $error("key_event_decoder: CNT_W too narrow for timing parameters");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DCLICK_GAP - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             short_nxt, long_nxt, repeat_nxt, dclick_nxt;
    logic             pr, rl;

    // A cycle with both pulses high is treated as carrying neither.
    assign pr = key_pressed & ~key_released;
    assign rl = key_released & ~key_pressed;

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        dclick_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pr) state_nxt = ST_HELD;
            end
            ST_HELD: begin
                if (rl) begin
                    state_nxt = ST_WAIT2;
                end else if (cnt == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    state_nxt = ST_LONG;
                end
            end
            ST_LONG: begin
                if (rl) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == REP_LAST) begin
                    repeat_nxt = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (pr) begin
                    dclick_nxt = 1'b1;
                    state_nxt  = ST_DRAIN;
                end else if (cnt == GAP_LAST) begin
                    short_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (rl) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) cnt_clr = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            double_click <= 1'b0;
            key_busy     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_clr ? '0 : cnt + CNT_W'(1);
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            repeat_tick  <= repeat_nxt;
            double_click <= dclick_nxt;
            key_busy     <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed gestures plus random press/hold/release
// sequences, checked every cycle against a timestamp-based gesture model.
module tb_key_event_decoder;

    localparam int LT  = 20;
    localparam int GAP = 8;
    localparam int RP  = 5;

    logic clk;
    logic rst;
    logic key_pressed, key_released;
    logic short_press, long_press, repeat_tick, double_click, key_busy;

    int vectors = 0;
    int errors  = 0;

    key_event_decoder #(
        .LONG_TIME    (LT),
        .DCLICK_GAP   (GAP),
        .REPEAT_PERIOD(RP),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_pressed (key_pressed),
        .key_released(key_released),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .double_click(double_click),
        .key_busy    (key_busy)
    );

    always #5 clk = ~clk;

    // Gesture model: remembers when the key went down / up and derives
    // events from elapsed time.
    int now = 0;
    int t_press = 0;
    int t_rel = 0;
    bit holding = 0, waiting = 0, draining = 0;

    function automatic logic [4:0] model(input logic p, input logic r, input logic rs);
        logic e_s, e_l, e_r, e_d;
        bit pp, rr;
        int age;
        e_s = 0; e_l = 0; e_r = 0; e_d = 0;
        now++;
        if (rs) begin
            holding = 0; waiting = 0; draining = 0;
            return 5'b0;
        end
        pp = p && !r;
        rr = r && !p;
        if (draining) begin
            if (rr) draining = 0;
        end else if (waiting) begin
            if (pp) begin
                e_d = 1; waiting = 0; draining = 1;
            end else if (now - t_rel == GAP) begin
                e_s = 1; waiting = 0;
            end
        end else if (holding) begin
            age = now - t_press;
            if (rr) begin
                holding = 0;
                if (age <= LT) begin
                    waiting = 1; t_rel = now;
                end
            end else if (age == LT) begin
                e_l = 1;
            end else if (age > LT && (age - LT) % RP == 0) begin
                e_r = 1;
            end
        end else if (pp) begin
            holding = 1; t_press = now;
        end
        return {e_s, e_l, e_r, e_d, (holding | waiting | draining)};
    endfunction

    // One clock edge: drive inputs, advance the model, sample just after the edge.
    task automatic step(input logic p, input logic r, input logic rs,
                        output logic [4:0] exp_v, output logic [4:0] act_v);
        key_pressed  = p;
        key_released = r;
        rst          = rs;
        @(posedge clk);
        exp_v = model(p, r, rs);
        #1;
        act_v = {short_press, long_press, repeat_tick, double_click, key_busy};
    endtask

    task automatic test_reset();
        logic [4:0] e, a;
        for (int i = 0; i < 4; i++) begin
            step(i[0], ~i[0], 1'b1, e, a);
            vectors++;
            if (a !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d act=%b exp=00000", now, a);
            end
        end
        step(1'b0, 1'b0, 1'b0, e, a);
        vectors++;
        if (a !== e || a[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release cyc%0d act=%b exp=%b", now, a, e);
        end
    endtask

    task automatic run_queue(input string name, input logic [2:0] q[$],
                             output int n_s, output int n_l, output int n_r, output int n_d);
        logic [4:0] e, a;
        n_s = 0; n_l = 0; n_r = 0; n_d = 0;
        foreach (q[i]) begin
            step(q[i][1], q[i][0], q[i][2], e, a);
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cyc%0d act=%b exp=%b", name, now, a, e);
            end
            n_s += int'(a[4]); n_l += int'(a[3]); n_r += int'(a[2]); n_d += int'(a[1]);
        end
    endtask

    task automatic test_short();
        logic [2:0] q[$];
        int s, l, r, d;
        q.push_back(3'b010);
        repeat (4) q.push_back(3'b000);
        q.push_back(3'b001);
        repeat (10) q.push_back(3'b000);
        run_queue("short", q, s, l, r, d);
        vectors++;
        if (s != 1 || l != 0 || r != 0 || d != 0) begin
            errors++;
            $display("FAIL short_counts act=%0d/%0d/%0d/%0d exp=1/0/0/0", s, l, r, d);
        end
    endtask

    task automatic test_long_repeat();
        logic [2:0] q[$];
        int s, l, r, d;
        q.push_back(3'b010);
        repeat (31) q.push_back(3'b000);
        q.push_back(3'b001);
        repeat (3) q.push_back(3'b000);
        run_queue("long_repeat", q, s, l, r, d);
        vectors++;
        if (s != 0 || l != 1 || r != 2 || d != 0) begin
            errors++;
            $display("FAIL long_counts act=%0d/%0d/%0d/%0d exp=0/1/2/0", s, l, r, d);
        end
    endtask

    task automatic test_double();
        logic [2:0] q[$];
        int s, l, r, d;
        q.push_back(3'b010);
        repeat (2) q.push_back(3'b000);
        q.push_back(3'b001);
        repeat (3) q.push_back(3'b000);
        q.push_back(3'b010);
        repeat (22) q.push_back(3'b000);
        q.push_back(3'b001);
        repeat (12) q.push_back(3'b000);
        run_queue("double", q, s, l, r, d);
        vectors++;
        if (s != 0 || l != 0 || r != 0 || d != 1) begin
            errors++;
            $display("FAIL double_counts act=%0d/%0d/%0d/%0d exp=0/0/0/1", s, l, r, d);
        end
    endtask

    task automatic test_boundaries();
        logic [2:0] q[$];
        int s, l, r, d;
        q.push_back(3'b010);
        repeat (LT - 1) q.push_back(3'b000);
        q.push_back(3'b001);               // release on the last HELD cycle
        repeat (GAP - 1) q.push_back(3'b000);
        q.push_back(3'b010);               // press on the last WAIT2 cycle
        repeat (3) q.push_back(3'b000);
        q.push_back(3'b001);
        repeat (3) q.push_back(3'b000);
        run_queue("boundaries", q, s, l, r, d);
        vectors++;
        if (s != 0 || l != 0 || r != 0 || d != 1) begin
            errors++;
            $display("FAIL boundary_counts act=%0d/%0d/%0d/%0d exp=0/0/0/1", s, l, r, d);
        end
    endtask

    task automatic test_robustness();
        logic [2:0] q[$];
        int s, l, r, d;
        q.push_back(3'b011);               // both pulses in IDLE
        repeat (2) q.push_back(3'b000);
        run_queue("both_high", q, s, l, r, d);
        vectors++;
        if (key_busy !== 1'b0) begin
            errors++;
            $display("FAIL both_high_busy act=%b exp=0", key_busy);
        end
        q.delete();
        q.push_back(3'b010);
        repeat (27) q.push_back(3'b000);
        run_queue("pre_reset_long", q, s, l, r, d);
        q.delete();
        q.push_back(3'b100);               // reset mid-LONG
        repeat (12) q.push_back(3'b000);
        run_queue("mid_long_reset", q, s, l, r, d);
        vectors++;
        if (r != 0 || l != 0) begin
            errors++;
            $display("FAIL reset_abort act=rep%0d/long%0d exp=0/0", r, l);
        end
    endtask

    task automatic test_random();
        logic [2:0] q[$];
        int s, l, r, d;
        int ts = 0, tl = 0, td = 0;
        for (int g = 0; g < 60; g++) begin
            q.delete();
            repeat ($urandom_range(0, 12)) q.push_back(3'b000);
            q.push_back(3'b010);
            repeat ($urandom_range(0, 34)) q.push_back(3'b000);
            q.push_back(3'b001);
            run_queue("random", q, s, l, r, d);
            ts += s; tl += l; td += d;
        end
        q.delete();
        repeat (LT) q.push_back(3'b000);
        run_queue("random_tail", q, s, l, r, d);
        ts += s;
        vectors++;
        if (ts == 0 || tl == 0 || td == 0) begin
            errors++;
            $display("FAIL random_coverage act=short%0d/long%0d/dclick%0d exp=all>0", ts, tl, td);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        key_pressed = 1'b0;
        key_released = 1'b0;
        test_reset();
        test_short();
        test_long_repeat();
        test_double();
        test_boundaries();
        test_robustness();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
